// File: rtl/kp_ctrl_pkg.sv
// Shared types and register map for the keypad polling controller.
package kp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_POLL     = 3'd1,
    ST_READ     = 3'd2,
    ST_ACK      = 3'd3,
    ST_WAIT_CLR = 3'd4
  } kp_state_t;

  localparam int KEY_W = 4;

  localparam logic [1:0] KP_ADDR_DATA   = 2'd0;
  localparam logic [1:0] KP_ADDR_STATUS = 2'd1;
  localparam logic [1:0] KP_ADDR_CTRL   = 2'd2;

  localparam int ST_BIT_EMPTY     = 0;
  localparam int ST_BIT_FULL      = 1;
  localparam int ST_BIT_OVF       = 2;
  localparam int ST_BIT_COUNT_LSB = 3;
  localparam int ST_COUNT_W       = 5;
  localparam int ST_BIT_BUSY      = 8;

  localparam int CTRL_BIT_EN      = 0;
  localparam int CTRL_BIT_IRQ_EN  = 1;
  localparam int CTRL_BIT_OVF_CLR = 2;

endpackage

// File: rtl/kp_key_fifo.sv
// Circular key buffer; a push while full is accepted only alongside a pop.
module kp_key_fifo
  import kp_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [KEY_W-1:0] push_key,
  output logic [KEY_W-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [KEY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_key;
  end

endmodule

// File: rtl/keypad_poll_ctrl.sv
// Polls the keypad ready bit, reads and acks each key into a FIFO, and
// exposes DATA/STATUS/CTRL registers plus a level interrupt to the CPU.
module keypad_poll_ctrl
  import kp_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter bit OVERFLOW_DROP = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_kp_rselect,
  output logic        o_kp_ack,
  input  logic [15:0] i_kp_data,
  input  logic [1:0]  i_cpu_addr,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  input  logic [15:0] i_cpu_wdata,
  output logic [15:0] o_cpu_rdata,
  output logic        o_irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  kp_state_t        state;
  kp_state_t        next_state;
  logic             enable;
  logic             irq_en;
  logic             ovf;
  logic             ack;
  logic [KEY_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             ctrl_wr;
  logic             busy;
  logic             unused_bits;

  assign unused_bits = ^{i_kp_data[15:KEY_W], i_cpu_wdata[15:3]};

  assign ctrl_wr = i_cpu_wr && (i_cpu_addr == KP_ADDR_CTRL);
  assign pop     = i_cpu_rd && (i_cpu_addr == KP_ADDR_DATA) && !empty;
  assign push    = (state == ST_READ) && (!full || pop);
  assign drop    = (state == ST_READ) && full && !pop && OVERFLOW_DROP;
  assign busy    = state inside {ST_READ, ST_ACK, ST_WAIT_CLR};

  kp_key_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .push     (push),
    .pop      (pop),
    .push_key (i_kp_data[KEY_W-1:0]),
    .head     (head),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  // Ack comes from a flop so it cannot glitch while the state bits change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      ack   <= 1'b0;
    end else begin
      state <= next_state;
      ack   <= (next_state == ST_ACK);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (enable) next_state = ST_POLL;
      ST_POLL: begin
        if (!enable)
          next_state = ST_IDLE;
        else if (i_kp_data[0] && !(full && !OVERFLOW_DROP))
          next_state = ST_READ;
      end
      ST_READ:     next_state = ST_ACK;
      ST_ACK:      next_state = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!i_kp_data[0]) next_state = enable ? ST_POLL : ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_kp_rselect = (state != ST_READ);
    o_kp_ack     = ack;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable <= i_cpu_wdata[CTRL_BIT_EN];
        irq_en <= i_cpu_wdata[CTRL_BIT_IRQ_EN];
      end
      if (drop)
        ovf <= 1'b1;
      else if (ctrl_wr && i_cpu_wdata[CTRL_BIT_OVF_CLR])
        ovf <= 1'b0;
    end
  end

  always_comb begin
    o_cpu_rdata = '0;
    case (i_cpu_addr)
      KP_ADDR_DATA: if (!empty) o_cpu_rdata[KEY_W-1:0] = head;
      KP_ADDR_STATUS: begin
        o_cpu_rdata[ST_BIT_EMPTY]                        = empty;
        o_cpu_rdata[ST_BIT_FULL]                         = full;
        o_cpu_rdata[ST_BIT_OVF]                          = ovf;
        o_cpu_rdata[ST_BIT_COUNT_LSB +: ST_COUNT_W]      = ST_COUNT_W'(count);
        o_cpu_rdata[ST_BIT_BUSY]                         = busy;
      end
      KP_ADDR_CTRL: begin
        o_cpu_rdata[CTRL_BIT_EN]     = enable;
        o_cpu_rdata[CTRL_BIT_IRQ_EN] = irq_en;
      end
      default: ;
    endcase
  end

  assign o_irq = irq_en & (!empty | ovf);

endmodule

// File: doc/keypad_poll_ctrl.md
Name: keypad_poll_ctrl

Overview:
- Bus-side controller for the 4x4 keypad peripheral: polls the peripheral's ready bit, reads the key code, pulses ack, and queues the key in a small FIFO.
- Exposes a 3-register CPU interface (DATA/STATUS/CTRL) and a level interrupt, so software never handshakes with the keypad directly.
- Sits between the CPU I/O bus and the keypad peripheral's i_rselect/i_ack/o_data pins.

Parameters:
- FIFO_DEPTH, 8, key FIFO entries (power of two, 2..16).
- OVERFLOW_DROP, 1, 1: when the FIFO is full, ack and discard the key and set ovf; 0: leave the key pending in the peripheral (no read, no ack) until space frees.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset; one clock, reset asynchronous and active-low.
- o_kp_rselect  output  1  to keypad i_rselect; 1 = status (ready in bit 0), 0 = key data.
- o_kp_ack  output  1  to keypad i_ack; single-cycle pulse.
- i_kp_data  input  16  from keypad o_data (combinational on o_kp_rselect).
- i_cpu_addr  input  2  0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved (reads 0).
- i_cpu_rd  input  1  read strobe; a DATA read pops the FIFO.
- i_cpu_wr  input  1  write strobe; only CTRL is writable.
- i_cpu_wdata  input  16  write data.
- o_cpu_rdata  output  16  combinational read data for i_cpu_addr.
- o_irq  output  1  level interrupt = irq_en & (!empty | ovf).

Behaviour:
- Reset state: FSM IDLE; enable=0, irq_en=0, ovf=0; FIFO empty. Outputs: o_kp_rselect=1, o_kp_ack=0, o_irq=0.
- FSM states are IDLE, POLL, READ, ACK, WAIT_CLR.
- IDLE: rselect=1. Go to POLL when enable=1.
- POLL: rselect=1.
  - If enable=0, go to IDLE.
  - Else if i_kp_data[0]=1: go to READ, unless the FIFO is full and OVERFLOW_DROP=0, in which case stay in POLL.
- READ: rselect=0. Sample i_kp_data[3:0] this cycle.
  - If the FIFO is not full, or a pop occurs in the same cycle, push the key.
  - Otherwise (DROP mode only) discard the key and set ovf.
  - Go to ACK.
- ACK: rselect=1, o_kp_ack=1 for exactly this cycle. Go to WAIT_CLR.
- WAIT_CLR: rselect=1.
  - When i_kp_data[0]=0, go to POLL if enable=1, else IDLE.
  - Otherwise stay. This prevents the same key being captured twice.
- Latency: ready seen in POLL at cycle n; pushed on the edge ending cycle n+1; count visible at n+2; ack at n+2. Minimum 4 cycles per key.
- Clearing enable mid-transaction: READ/ACK/WAIT_CLR complete normally, then the FSM goes to IDLE. A transaction is never abandoned.
- DATA read (rd, addr 0):
  - rdata = {12'b0, head}.
  - Pop on the edge if not empty.
  - Empty: rdata=0, no pop, no state change.
- STATUS read (addr 1), no side effects. Bit assignment:
  - bit 0: empty
  - bit 1: full
  - bit 2: ovf
  - bits 7:3: count (5 bits)
  - bit 8: busy (state not IDLE/POLL)
  - others 0
- CTRL:
  - Read bit 0: enable, bit 1: irq_en.
  - Write bit 0: enable, bit 1: irq_en, bit 2: clear ovf (write-1, self-clearing).
  - ovf set by a drop in the same cycle as a clear: set wins.
- FIFO: circular buffer with read/write pointers and count.
  - Simultaneous push and pop: both happen, count unchanged; legal when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is $clog2(FIFO_DEPTH)+1.
- rd and wr in the same cycle: both are honoured (distinct registers).
- Asynchronous reset at any point returns everything to reset values immediately. o_kp_ack must never glitch high during reset.

Decomposition:
- Package kp_ctrl_pkg holds:
  - state enum type kp_state_t;
  - register address constants KP_ADDR_DATA/STATUS/CTRL;
  - STATUS and CTRL bit-position constants.
- One sub-module, kp_key_fifo: parameterised synchronous FIFO, width 4, with push/pop/head/count/empty/full, same clock and async active-low reset. The FSM, registers and read mux stay in the top.

Test Plan:
- Enable=1; keypad model raises ready with key 0x5 → rselect goes 1→0→1; one ack pulse 2 cycles after ready is seen; STATUS count=1, empty=0; DATA read returns 0x0005; then empty=1.
- Ready held high for 3 cycles after ack (slow clear) → FSM stays in WAIT_CLR; exactly one push; no second ack.
- FIFO_DEPTH=8, DROP=1, 9 keys with no reads → count=8, full=1, ovf=1, 9th key acked and discarded; irq_en=1 gives o_irq=1; CTRL write 0x4 clears ovf; the 8 reads return keys 1..8 in order.
- DROP=0, FIFO full, key pending → no ack and rselect stays 1; one DATA read → key read and acked within 4 cycles; count returns to 8.
- Key pushed in the same cycle as a DATA pop while full → count stays 8 and order is preserved. Empty DATA read returns 0 with no pointer change.
- Assert i_rst_n low during ACK → o_kp_ack=0 immediately, FIFO empty, enable=0. After release with no enable write, the FSM stays in IDLE.
